redirect_flush_ctrl: RTL and testbench

//  Parametrised control-flow redirect unit for the pipelined RISC-V core; replaces fixed 2-cycle branch squash.

---
 rtl/riscv_pipe_pkg.sv | 18 +
 rtl/redirect_prio_enc.sv | 24 ++
 rtl/redirect_flush_ctrl.sv | 159 +++++++++++++++
 tb/tb_redirect_flush_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V core: redirect FSM states,
// pipeline stage indices and redirect source indices.
package riscv_pipe_pkg;

    typedef enum logic {
        RF_IDLE = 1'b0,
        RF_WAIT = 1'b1
    } rf_state_e;

    // Flushable stage registers, youngest first
    localparam int STG_IFID = 0;
    localparam int STG_IDEX = 1;

    // Redirect sources, oldest (highest priority) first
    localparam int SRC_EX = 0;
    localparam int SRC_ID = 1;

endpackage

// File: rtl/redirect_prio_enc.sv
// Lowest-index-wins priority encoder for redirect requests.
// idx reads N when no request is present.
module redirect_prio_enc #(
    parameter int N  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx = IW'(N);
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/redirect_flush_ctrl.sv
// Control-flow redirect unit: arbitrates prioritised redirect requests, holds
// the winning target for TGT_LAT cycles, then pulses pc_redirect for one
// cycle while squashing the affected stage registers for the whole window.
// Optional macro REDIRECT_STATS_EN adds redirect and squash event counters.
module redirect_flush_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int TGT_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [NUM_SRC-1:0]      red_v,
    input  logic [NUM_SRC*XLEN-1:0] red_tgt,
    output logic                    pc_redirect,
    output logic [XLEN-1:0]         pc_target,
    output logic [NUM_SRC-1:0]      flush_n,
    output logic                    busy
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]             redirect_cnt,
    output logic [31:0]             squash_cnt
`endif
);

    localparam int IW = $clog2(NUM_SRC + 1);
    localparam int CW = (TGT_LAT > 1) ? $clog2(TGT_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((TGT_LAT > 0) ? TGT_LAT - 1 : 0);

    rf_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;

    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic [XLEN-1:0]   win_tgt;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [NUM_SRC-1:0] squash;

    // Source i squashes stage j when j <= NUM_SRC-1-i; src==NUM_SRC squashes nothing
    function automatic logic [NUM_SRC-1:0] flush_mask(input logic [IW-1:0] src);
        flush_mask = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (int'(src) < NUM_SRC && j <= NUM_SRC - 1 - int'(src))
                flush_mask[j] = 1'b1;
        end
    endfunction

    redirect_prio_enc #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .req (red_v),
        .idx (win_idx),
        .any (win_any)
    );

    // Select the winning source's target from the flat bus
    always_comb begin
        win_tgt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IW'(i) == win_idx)
                win_tgt = red_tgt[i*XLEN +: XLEN];
        end
    end

    // Control state: async active-low reset abandons any open window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            idx_q   <= IW'(NUM_SRC);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Held target is data only; it is never observed outside a live window
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
    end

    // Next-state, countdown, preemption and combinational redirect/flush outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        redirect = 1'b0;
        target   = '0;
        squash   = '0;
        case (state_q)
            RF_IDLE: begin
                if (win_any) begin
                    squash = flush_mask(win_idx);
                    if (TGT_LAT == 0) begin
                        redirect = 1'b1;
                        target   = win_tgt;
                    end else begin
                        state_d = RF_WAIT;
                        cnt_d   = CNT_INIT;
                        idx_d   = win_idx;
                        tgt_d   = win_tgt;
                    end
                end
            end
            RF_WAIT: begin
                squash = flush_mask(idx_q);
                if (!stall) begin
                    if (cnt_q == '0) begin
                        // Issue wins over any request seen in the same cycle
                        redirect = 1'b1;
                        target   = tgt_q;
                        state_d  = RF_IDLE;
                        idx_d    = IW'(NUM_SRC);
                    end else if (win_any && win_idx < idx_q) begin
                        // Older stage redirects: restart the window, widen the squash
                        cnt_d  = CNT_INIT;
                        idx_d  = win_idx;
                        tgt_d  = win_tgt;
                        squash = flush_mask(win_idx);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    // Outputs sit at their reset values for as long as reset is held
    always_comb begin
        pc_redirect = redirect & rst;
        pc_target   = rst ? target : '0;
        flush_n     = ~(squash & {NUM_SRC{rst}});
        busy        = rst && (state_q == RF_WAIT);
    end

`ifdef REDIRECT_STATS_EN
    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt <= '0;
            squash_cnt   <= '0;
        end else begin
            redirect_cnt <= redirect_cnt + {31'd0, pc_redirect};
            squash_cnt   <= squash_cnt + {31'd0, ~&flush_n};
        end
    end
`endif

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// Testbench for redirect_flush_ctrl: a TGT_LAT=2 instance and a TGT_LAT=0
// instance driven by the same stimulus, each checked every cycle against a
// request-level reference model. Honours REDIRECT_STATS_EN when defined.
module tb_redirect_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  red_v;
    logic [63:0] red_tgt;

    logic        red2, red0;
    logic [31:0] tgt2, tgt0;
    logic [1:0]  fn2, fn0;
    logic        busy2, busy0;
`ifdef REDIRECT_STATS_EN
    logic [31:0] rcnt2, scnt2, rcnt0, scnt0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    redirect_flush_ctrl #(.XLEN(32), .NUM_SRC(2), .TGT_LAT(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .red_v(red_v), .red_tgt(red_tgt),
        .pc_redirect(red2), .pc_target(tgt2), .flush_n(fn2), .busy(busy2)
`ifdef REDIRECT_STATS_EN
        , .redirect_cnt(rcnt2), .squash_cnt(scnt2)
`endif
    );

    redirect_flush_ctrl #(.XLEN(32), .NUM_SRC(2), .TGT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .red_v(red_v), .red_tgt(red_tgt),
        .pc_redirect(red0), .pc_target(tgt0), .flush_n(fn0), .busy(busy0)
`ifdef REDIRECT_STATS_EN
        , .redirect_cnt(rcnt0), .squash_cnt(scnt0)
`endif
    );

    // Pending redirect as the model sees it: who asked, where to, cycles left
    typedef struct packed {
        bit          act;
        int          src;
        logic [31:0] tgt;
        int          rem;
    } mstate_t;

    typedef struct packed {
        bit          red;
        logic [31:0] tgt;
        logic [1:0]  fn;
        bit          busy;
    } mout_t;

    mstate_t m2, m0;
    int rc2 = 0, sc2 = 0, rc0 = 0, sc0 = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] squash_n(input int src);
        logic [1:0] r;
        r = 2'b11;
        for (int j = 0; j < 2; j++)
            if (j <= 1 - src) r[j] = 1'b0;
        return r;
    endfunction

    function automatic void model_step(input mstate_t s, input int lat, input bit rst_n,
                                       input logic [1:0] v, input logic [63:0] t, input bit st,
                                       output mout_t o, output mstate_t ns);
        int w;
        logic [31:0] wt;
        o  = '{red: 1'b0, tgt: 32'd0, fn: 2'b11, busy: 1'b0};
        ns = s;
        if (!rst_n) begin
            ns = '{act: 1'b0, src: 2, tgt: 32'd0, rem: 0};
            return;
        end
        w  = v[0] ? 0 : (v[1] ? 1 : 2);
        wt = (w == 0) ? t[31:0] : t[63:32];
        if (!s.act) begin
            if (w < 2) begin
                o.fn = squash_n(w);
                if (lat == 0) begin
                    o.red = 1'b1;
                    o.tgt = wt;
                end else begin
                    ns = '{act: 1'b1, src: w, tgt: wt, rem: lat - 1};
                end
            end
        end else begin
            o.busy = 1'b1;
            o.fn   = squash_n(s.src);
            if (!st) begin
                if (s.rem == 0) begin
                    o.red = 1'b1;
                    o.tgt = s.tgt;
                    ns.act = 1'b0;
                end else if (w < s.src) begin
                    ns   = '{act: 1'b1, src: w, tgt: wt, rem: lat - 1};
                    o.fn = squash_n(w);
                end else begin
                    ns.rem = s.rem - 1;
                end
            end
        end
    endfunction

    task automatic compare_both();
        mout_t o2, o0;
        mstate_t n2, n0;
        model_step(m2, 2, rst, red_v, red_tgt, stall, o2, n2);
        model_step(m0, 0, rst, red_v, red_tgt, stall, o0, n0);
        check_val("lat2_redirect", 64'(red2), 64'(o2.red));
        check_val("lat2_target",   64'(tgt2), 64'(o2.tgt));
        check_val("lat2_flush_n",  64'(fn2),  64'(o2.fn));
        check_val("lat2_busy",     64'(busy2), 64'(o2.busy));
        check_val("lat0_redirect", 64'(red0), 64'(o0.red));
        check_val("lat0_target",   64'(tgt0), 64'(o0.tgt));
        check_val("lat0_flush_n",  64'(fn0),  64'(o0.fn));
        check_val("lat0_busy",     64'(busy0), 64'(o0.busy));
`ifdef REDIRECT_STATS_EN
        check_val("lat2_redirect_cnt", 64'(rcnt2), 64'(rc2));
        check_val("lat2_squash_cnt",   64'(scnt2), 64'(sc2));
        check_val("lat0_redirect_cnt", 64'(rcnt0), 64'(rc0));
        check_val("lat0_squash_cnt",   64'(scnt0), 64'(sc0));
`endif
        if (rst) begin
            rc2 += int'(o2.red); sc2 += int'(o2.fn != 2'b11);
            rc0 += int'(o0.red); sc0 += int'(o0.fn != 2'b11);
        end else begin
            rc2 = 0; sc2 = 0; rc0 = 0; sc0 = 0;
        end
        m2 = n2;
        m0 = n0;
    endtask

    // One clock: drive after the edge, check mid-cycle, model advances at the next edge
    task automatic cycle(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1, input bit st);
        @(posedge clk);
        #2;
        red_v   = v;
        red_tgt = {t1, t0};
        stall   = st;
        #2;
        compare_both();
    endtask

    // Asynchronous reset in the middle of a cycle, released before the next edge
    task automatic reset_pulse();
        #1;
        rst   = 1'b0;
        red_v = 2'b00;
        stall = 1'b0;
        #1;
        compare_both();
        rc2 = 0; sc2 = 0; rc0 = 0; sc0 = 0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] v;
        rst     = 1'b0;
        stall   = 1'b0;
        red_v   = 2'b00;
        red_tgt = '0;
        m2 = '{act: 1'b0, src: 2, tgt: 32'd0, rem: 0};
        m0 = m2;

        // Reset state, with a request present to prove outputs are held off
        cycle(2'b00, 32'h0, 32'h0, 1'b0);
        cycle(2'b01, 32'h44, 32'h0, 1'b0);
        red_v = 2'b00;
        #3 rst = 1'b1;

        // EX branch
        cycle(2'b00, 32'h0, 32'h0, 1'b0);
        cycle(2'b01, 32'h100, 32'h0, 1'b0);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // ID jump
        cycle(2'b10, 32'h0, 32'h200, 1'b0);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // Preempt of ID jump by EX branch
        cycle(2'b10, 32'h0, 32'h200, 1'b0);
        cycle(2'b01, 32'h300, 32'h0, 1'b0);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // Wrong-path younger request during a window is ignored
        cycle(2'b01, 32'h340, 32'h0, 1'b0);
        cycle(2'b10, 32'h0, 32'h380, 1'b0);
        repeat (2) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // Stall inside the window
        cycle(2'b01, 32'h400, 32'h0, 1'b0);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // Request on the issue cycle is taken afterwards only if still present
        cycle(2'b10, 32'h0, 32'h480, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 1'b0);
        cycle(2'b01, 32'h4c0, 32'h0, 1'b0);
        cycle(2'b01, 32'h4c0, 32'h0, 1'b0);
        repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0);
        // Reset mid-window
        cycle(2'b01, 32'h500, 32'h0, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 1'b0);
        reset_pulse();
        repeat (4) cycle(2'b00, 32'h0, 32'h0, 1'b0);

        // Random traffic with stalls and the occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(v, $urandom, $urandom, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
